// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Edge driver for an N x N systolic MAC array. Takes one A/B vector pair per beat and
// drives diagonally skewed lanes into the array's left column and top row. It also
// sequences one K-beat job as clear, feed, flush and done. A global waitrequest freezes
// all state, so the feeder stays in lockstep with the PEs.
module systolic_skew_feeder #(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_W      = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        k_len,
    input  logic                    vec_valid,
    output logic                    vec_ready,
    input  logic [N*DATA_WIDTH-1:0] a_vec,
    input  logic [N*DATA_WIDTH-1:0] b_vec,
    input  logic                    waitrequest,
    output logic [N*DATA_WIDTH-1:0] left_out,
    output logic [N*DATA_WIDTH-1:0] top_out,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    done
);

    // Flush lasts 2N-1 advance cycles. These are skew drain, array propagate and the
    // final accumulate.
    localparam int unsigned        FLUSH_W    = $clog2(2 * N);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(2 * N - 2);

    typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   k_len_q, k_len_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   beat_cnt_inc;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;

    logic                    advance;
    logic                    beat;
    logic [N*DATA_WIDTH-1:0] a_in;
    logic [N*DATA_WIDTH-1:0] b_in;

    assign advance      = ~waitrequest;
    assign beat         = (state_q == StFeed) & vec_valid & advance;
    assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

    // A cycle without an accepted beat pushes zeros down every lane. This keeps the A and
    // B wavefronts aligned.
    assign a_in = beat ? a_vec : '0;
    assign b_in = beat ? b_vec : '0;

    // State and counter registers. They load only on advance cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else if (advance) begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state and counter values, assuming the cycle advances.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_len_d     = k_len;
                    beat_cnt_d  = '0;
                    flush_cnt_d = '0;
                    state_d     = (k_len != '0) ? StFeed : StDone;
                end
            end
            StFeed: begin
                if (vec_valid) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (beat_cnt_inc == k_len_q) begin
                        state_d     = StFlush;
                        flush_cnt_d = '0;
                    end
                end
            end
            StFlush: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = StDone;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake and pulse outputs. acc_clr and done are forced low when stalled or in reset.
    always_comb begin
        vec_ready = 1'b0;
        acc_clr   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                acc_clr = start & advance & ~rst;
            end
            StFeed: begin
                vec_ready = advance & ~rst;
                busy      = ~rst;
            end
            StFlush: begin
                busy = ~rst;
            end
            StDone: begin
                done = advance & ~rst;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Lane i is a delay line of i+1 stages. The last stage drives the array edge.
    for (genvar i = 0; i < N; i++) begin : g_lane
        for (genvar s = 0; s <= i; s++) begin : g_stage
            logic [DATA_WIDTH-1:0] a_q;
            logic [DATA_WIDTH-1:0] b_q;
            logic [DATA_WIDTH-1:0] a_next;
            logic [DATA_WIDTH-1:0] b_next;

            if (s == 0) begin : g_head
                assign a_next = a_in[i*DATA_WIDTH +: DATA_WIDTH];
                assign b_next = b_in[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_body
                assign a_next = g_stage[s-1].a_q;
                assign b_next = g_stage[s-1].b_q;
            end

            // One skew stage. It shifts only on advance cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_next;
                    b_q <= b_next;
                end
            end
        end

        assign left_out[i*DATA_WIDTH +: DATA_WIDTH] = g_stage[i].a_q;
        assign top_out[i*DATA_WIDTH +: DATA_WIDTH]  = g_stage[i].b_q;
    end

endmodule
